// File: rtl/mux_n_skid_pkg.sv
// Shared types and constants for the N-way selector with skid stage.
// Holds the occupancy encoding, default sizing and the select-width derivation.
// No logic of its own; imported by mux_n_comb and mux_n_skid.
package mux_n_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_IN  = 4;

    function automatic int calc_sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N_IN:1 selector with out-of-range select detect.
// Latency: zero (purely combinational).
// Backpressure: none; the caller decides when the result is captured.
module mux_n_comb
    import mux_n_skid_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_IN  = DEF_N_IN,
    parameter int SEL_W = calc_sel_w(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_of_range
);

    // An unmatched select yields zero data and raises the flag.
    always_comb begin
        out_data     = '0;
        out_of_range = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data     = in_data[k*WIDTH +: WIDTH];
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_skid.sv
// N-way WIDTH-bit selector feeding a 2-entry registered skid stage (main + skid).
// Latency: one cycle from accept to out_valid; 1 transfer/cycle while out_ready=1.
// Backpressure: in_ready is registered and drops only when both entries are held.
module mux_n_skid
    import mux_n_skid_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_IN  = DEF_N_IN,
    parameter int SEL_W = calc_sel_w(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    skid_state_e       state_q, state_d;
    logic [WIDTH-1:0]  main_dat, skid_dat, sel_dat;
    logic [SEL_W-1:0]  main_sel, skid_sel;
    logic              in_ready_q, sel_err_q, sel_oor;
    logic              in_fire, out_fire;
    logic              load_main, load_skid, main_from_skid;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_data      (in_data),
        .sel          (in_sel),
        .out_data     (sel_dat),
        .out_of_range (sel_oor)
    );

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Data is left untouched by flush; only occupancy is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_dat <= '0;
            main_sel <= '0;
            skid_dat <= '0;
            skid_sel <= '0;
        end else begin
            if (load_main) begin
                main_dat <= sel_dat;
                main_sel <= in_sel;
            end else if (main_from_skid) begin
                main_dat <= skid_dat;
                main_sel <= skid_sel;
            end
            if (load_skid) begin
                skid_dat <= sel_dat;
                skid_sel <= in_sel;
            end
        end
    end

    // Sticky error: any completed upstream handshake with a bad select counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (in_fire && sel_oor) begin
            sel_err_q <= 1'b1;
        end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_dat;
    assign out_sel   = main_sel;
    assign in_ready  = in_ready_q;
    assign sel_err   = sel_err_q;

endmodule

// File: doc/mux_n_skid.md
Name: mux_n_skid

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered 2-entry skid stage and valid/ready handshake on both sides.
- Successor to the plain combinational 4:1 datapath selector. It adds:
  - arbitrary input count and width,
  - one cycle of registered latency,
  - full-throughput back-pressure,
  - flush,
  - out-of-range select detection.
- Sits between pipeline stages of the RISC-V core, e.g. operand/writeback select feeding a stage that can stall.

Parameters:
- WIDTH, 32: data width of each input and of the output.
- N_IN, 4: number of data inputs; legal range 2..16.
- SEL_W, $clog2(N_IN): select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  selects input index for this transfer
- in_valid  input  1  upstream offers a transfer
- in_ready  output  1  block can accept; registered, depends only on occupancy
- flush  input  1  synchronous discard of all held and incoming entries
- out_data  output  WIDTH  selected data of head entry
- out_sel  output  SEL_W  select value that produced out_data
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts
- sel_err  output  1  sticky: an accepted transfer had in_sel >= N_IN

Behaviour:
- Reset (rst_n low, asynchronous):
  - state EMPTY;
  - out_valid=0, out_data=0, out_sel=0;
  - in_ready=1, sel_err=0.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Data capture:
  - Data is selected combinationally at capture: entry data = in_data[in_sel] if in_sel < N_IN, else 0.
  - Selected data and in_sel are stored together.
- States: EMPTY (0 entries), ONE (main reg valid), FULL (main + skid valid).
- Transitions:
  - EMPTY: in_fire -> ONE; main loads the new entry.
  - ONE, in_fire & !out_fire -> FULL; skid loads the new entry.
  - ONE, out_fire & !in_fire -> EMPTY.
  - ONE, in_fire & out_fire -> ONE; main loads the new entry.
  - FULL: out_fire -> ONE; main <= skid. No input is accepted in FULL.
- Outputs are driven from the main register:
  - out_valid = (state != EMPTY);
  - in_ready = (state != FULL), registered.
- Latency: accept at edge t -> out_valid=1 with that data after edge t, i.e. visible in cycle t+1. Throughput is 1 transfer/cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry never overtakes main.
- Holding rule: while out_valid=1 and out_ready=0, out_data and out_sel are held stable.
- flush:
  - Priority over all handshakes; next state EMPTY, in_ready=1.
  - An in_fire in the same cycle is discarded (upstream sees the handshake complete).
  - out_fire in the flush cycle is still a legal consume.
  - sel_err is unaffected.
- sel_err:
  - Set on in_fire with in_sel >= N_IN; only possible when N_IN is not a power of two.
  - Cleared only by rst_n.
  - An erroneous entry still flows through with data 0.
- Data registers are not cleared on flush; only valid/state are cleared.
- Reset asserted mid-transfer: all entries are lost immediately; outputs take their reset values asynchronously.

Decomposition:
- Shared package:
  - skid-state enum (EMPTY/ONE/FULL),
  - default WIDTH/N_IN constants,
  - SEL_W derivation function.
- Sub-module mux_n_comb: parametrised combinational N_IN:1 selector with the out-of-range detect flag. It is instantiated once at the input side.
- The skid/state logic stays in mux_n_skid.

Test Plan:
- Reset, then N_IN=4, WIDTH=32, inputs 0x11,0x22,0x33,0x44, sel=2, in_valid=1, out_ready=1:
  - out_valid=1 with out_data=0x33, out_sel=2 one cycle after accept;
  - back-to-back sel 0,1,3 -> 0x11, 0x22, 0x44 on consecutive cycles.
- out_ready=0, push sel=1 then sel=3:
  - in_ready drops after the second accept;
  - out_data held at 0x22;
  - raise out_ready -> 0x22 then 0x44;
  - in_ready returns 1 one cycle after the first pop.
- FULL, then assert flush with in_valid=1:
  - next cycle out_valid=0, in_ready=1;
  - the flushed-cycle input never appears at out_data.
- N_IN=3, push in_sel=3:
  - sel_err=1 the cycle after accept;
  - out_data=0, out_sel=3;
  - sel_err stays 1 through flush and clears only on rst_n.
- rst_n pulsed low while FULL with out_ready=0:
  - out_valid=0 immediately (asynchronous), in_ready=1, out_data=0;
  - after release, a new push of sel=0 yields 0x11.
- Random valid/ready at 50%, 1000 transfers, N_IN=5, WIDTH=8:
  - scoreboard order and data match;
  - no drops or duplicates;
  - out_data stable whenever out_valid & !out_ready.
